mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a single-cycle word memory.
// Aligns store data into byte lanes, extracts and extends load data, and rejects bad requests.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic        iwReqValid,
    output logic        owReqReady,
    input  logic        iwReqWrite,
    input  logic [1:0]  iwReqSize,
    input  logic        iwReqSigned,
    input  logic [31:0] iwReqAddr,
    input  logic [31:0] iwReqData,
    output logic        owRespValid,
    input  logic        iwRespReady,
    output logic [31:0] owRespData,
    output logic        owRespFault,
    output logic [31:0] owMemReadAddr,
    output logic [31:0] owMemWriteAddr,
    output logic [31:0] owMemWriteData,
    output logic [3:0]  owMemWstrb,
    input  logic [31:0] iwMemReadData
);

    // state       | meaning
    // S_IDLE      | ready for a request
    // S_WRITE     | write strobes driven to memory for one cycle
    // S_LOAD_ADDR | read address presented, memory fetching
    // S_LOAD_DATA | read data valid, captured at the end of this cycle
    // S_RESP      | response held until the CPU accepts it
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_LOAD_ADDR,
        S_LOAD_DATA,
        S_RESP
    } state_t;

    localparam logic [1:0]  SZ_BYTE  = 2'b00;
    localparam logic [1:0]  SZ_HALF  = 2'b01;
    localparam logic [1:0]  SZ_WORD  = 2'b10;
    localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_fault_q, resp_fault_d;

    logic        req_fault;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        req_fault = 1'b0;
        case (iwReqSize)
            SZ_BYTE: req_fault = 1'b0;
            SZ_HALF: req_fault = iwReqAddr[0];
            SZ_WORD: req_fault = (iwReqAddr[1:0] != 2'b00);
            default: req_fault = 1'b1;
        endcase
        if (iwReqAddr >= MEM_SIZE) begin
            req_fault = 1'b1;
        end
    end

    always_comb begin
        st_data = iwReqData;
        st_strb = 4'b1111;
        case (iwReqSize)
            SZ_BYTE: begin
                st_data = {4{iwReqData[7:0]}};
                st_strb = 4'b0001 << iwReqAddr[1:0];
            end
            SZ_HALF: begin
                st_data = {2{iwReqData[15:0]}};
                st_strb = iwReqAddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = iwReqData;
                st_strb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = iwMemReadData[8*lane_q +: 8];
        ld_half = lane_q[1] ? iwMemReadData[31:16] : iwMemReadData[15:0];
        case (size_q)
            SZ_BYTE: ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_data = iwMemReadData;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lane_d       = lane_q;
        size_d       = size_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        case (state_q)
            S_IDLE: begin
                if (iwReqValid) begin
                    addr_d       = {iwReqAddr[31:2], 2'b00};
                    lane_d       = iwReqAddr[1:0];
                    size_d       = iwReqSize;
                    signed_d     = iwReqSigned;
                    resp_data_d  = 32'h0;
                    resp_fault_d = req_fault;
                    wdata_d      = req_fault ? 32'h0 : st_data;
                    wstrb_d      = req_fault ? 4'h0 : st_strb;
                    if (req_fault) begin
                        state_d = S_RESP;
                    end else if (iwReqWrite) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_LOAD_ADDR;
                    end
                end
            end
            S_WRITE:     state_d = S_RESP;
            S_LOAD_ADDR: state_d = S_LOAD_DATA;
            S_LOAD_DATA: begin
                resp_data_d = ld_data;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (iwRespReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0;
            lane_q       <= 2'b00;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            resp_data_q  <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign owReqReady     = (state_q == S_IDLE);
    assign owRespValid    = (state_q == S_RESP);
    assign owRespData     = resp_data_q;
    assign owRespFault    = resp_fault_q;
    assign owMemReadAddr  = addr_q;
    assign owMemWriteAddr = addr_q;
    assign owMemWriteData = wdata_q;
    // Reset gates the strobes combinationally so a write in flight never lands.
    assign owMemWstrb     = (state_q == S_WRITE && !iwRst) ? wstrb_q : 4'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus backpressure and reset sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_signed, resp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_data;
    logic        req_ready, resp_valid, resp_fault;
    logic [31:0] resp_data, mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic [31:0] mem [0:63];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(256)) dut (
        .iwClk(clk), .iwRst(rst),
        .iwReqValid(req_valid), .owReqReady(req_ready),
        .iwReqWrite(req_write), .iwReqSize(req_size), .iwReqSigned(req_signed),
        .iwReqAddr(req_addr), .iwReqData(req_data),
        .owRespValid(resp_valid), .iwRespReady(resp_ready),
        .owRespData(resp_data), .owRespFault(resp_fault),
        .owMemReadAddr(mem_raddr), .owMemWriteAddr(mem_waddr),
        .owMemWriteData(mem_wdata), .owMemWstrb(mem_wstrb),
        .iwMemReadData(mem_rdata)
    );

    // Memory model: registered read (one-cycle latency), byte-lane writes.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_raddr[7:2]];
        for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) mem[mem_waddr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] data, input logic fault,
                       input logic [31:0] rdata, input int lat, input logic [3:0] strb,
                       input logic [31:0] wdata);
        vec_t v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.data = data;
        v.fault = fault; v.rdata = rdata; v.lat = lat; v.strb = strb; v.wdata = wdata;
        vecs.push_back(v);
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] data, input string name);
        @(negedge clk);
        chk({name, " ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = wr; req_size = size; req_signed = sgn;
        req_addr = addr; req_data = data;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        int lat, strb_cnt;
        logic [3:0]  got_strb;
        logic [31:0] got_wdata, got_waddr;
        nm = $sformatf("vec%0d", idx);
        drive_req(v.wr, v.size, v.sgn, v.addr, v.data, nm);
        lat = 0; strb_cnt = 0; got_strb = 4'h0; got_wdata = 32'h0; got_waddr = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_wstrb != 4'h0) begin
                strb_cnt++;
                got_strb = mem_wstrb; got_wdata = mem_wdata; got_waddr = mem_waddr;
            end
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'(v.lat));
        chk({nm, " fault"}, {31'h0, resp_fault}, {31'h0, v.fault});
        chk({nm, " data"}, resp_data, v.rdata);
        if (v.wr && !v.fault) begin
            chk({nm, " strb_cycles"}, 32'(strb_cnt), 32'd1);
            chk({nm, " strb"}, {28'h0, got_strb}, {28'h0, v.strb});
            chk({nm, " wdata"}, got_wdata, v.wdata);
            chk({nm, " waddr"}, got_waddr, {v.addr[31:2], 2'b00});
        end else begin
            chk({nm, " strb_cycles"}, 32'(strb_cnt), 32'd0);
        end
        if (!v.fault) chk({nm, " raddr"}, mem_raddr, {v.addr[31:2], 2'b00});
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk({nm, " exit"}, {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h80FF7F01;
        mem[1] = 32'h11223344;
        mem[4] = 32'h5A5A5A5A;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_data = 32'h0; resp_ready = 1'b0;

        //  wr  size   sgn  addr    data          flt  rdata         lat strb     wdata
        add(0, 2'b00, 1, 32'h02, 32'h0,        0, 32'hFFFFFFFF, 3, 4'h0, 32'h0);
        add(0, 2'b00, 0, 32'h03, 32'h0,        0, 32'h00000080, 3, 4'h0, 32'h0);
        add(0, 2'b01, 1, 32'h02, 32'h0,        0, 32'hFFFF80FF, 3, 4'h0, 32'h0);
        add(0, 2'b01, 0, 32'h02, 32'h0,        0, 32'h000080FF, 3, 4'h0, 32'h0);
        add(0, 2'b01, 1, 32'h00, 32'h0,        0, 32'h00007F01, 3, 4'h0, 32'h0);
        add(0, 2'b00, 1, 32'h01, 32'h0,        0, 32'h0000007F, 3, 4'h0, 32'h0);
        add(0, 2'b10, 1, 32'h00, 32'h0,        0, 32'h80FF7F01, 3, 4'h0, 32'h0);
        add(1, 2'b00, 0, 32'h05, 32'h000000AB, 0, 32'h0,        2, 4'b0010, 32'hABABABAB);
        add(0, 2'b10, 0, 32'h04, 32'h0,        0, 32'h1122AB44, 3, 4'h0, 32'h0);
        add(1, 2'b01, 0, 32'h0A, 32'h1234BEEF, 0, 32'h0,        2, 4'b1100, 32'hBEEFBEEF);
        add(0, 2'b01, 1, 32'h0A, 32'h0,        0, 32'hFFFFBEEF, 3, 4'h0, 32'h0);
        add(1, 2'b10, 0, 32'h0C, 32'hCAFEBABE, 0, 32'h0,        2, 4'b1111, 32'hCAFEBABE);
        add(0, 2'b00, 1, 32'h0F, 32'h0,        0, 32'hFFFFFFCA, 3, 4'h0, 32'h0);
        add(0, 2'b10, 0, 32'h06, 32'h0,        1, 32'h0,        1, 4'h0, 32'h0);
        add(0, 2'b11, 0, 32'h00, 32'h0,        1, 32'h0,        1, 4'h0, 32'h0);
        add(0, 2'b00, 0, 32'h100, 32'h0,       1, 32'h0,        1, 4'h0, 32'h0);
        add(1, 2'b01, 0, 32'h01, 32'h0000FFFF, 1, 32'h0,        1, 4'h0, 32'h0);
        add(1, 2'b10, 0, 32'h102, 32'hFFFFFFFF, 1, 32'h0,       1, 4'h0, 32'h0);
        add(1, 2'b00, 0, 32'hFF, 32'h00000077, 0, 32'h0,        2, 4'b1000, 32'h77777777);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", {31'h0, req_ready}, 32'h1);
        chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst resp_data", resp_data, 32'h0);
        chk("rst fault", {31'h0, resp_fault}, 32'h0);
        chk("rst raddr", mem_raddr, 32'h0);
        chk("rst wstrb", {28'h0, mem_wstrb}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
        chk("mem word1", mem[1], 32'h1122AB44);
        chk("mem word63", mem[63], 32'h77000000);

        // Backpressure: response held for 5 cycles.
        drive_req(0, 2'b10, 0, 32'h0, 32'h0, "bp");
        repeat (3) @(negedge clk);
        chk("bp valid", {31'h0, resp_valid}, 32'h1);
        for (int c = 0; c < 5; c++) begin
            chk("bp hold valid", {31'h0, resp_valid}, 32'h1);
            chk("bp hold data", resp_data, 32'h80FF7F01);
            chk("bp hold fault", {31'h0, resp_fault}, 32'h0);
            chk("bp hold ready", {31'h0, req_ready}, 32'h0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("bp idle ready", {31'h0, req_ready}, 32'h1);
        chk("bp idle valid", {31'h0, resp_valid}, 32'h0);

        // Reset during WRITE: strobes gated, memory untouched, no response.
        drive_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, "rstw");
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rstw wstrb", {28'h0, mem_wstrb}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstw no resp", {31'h0, resp_valid}, 32'h0);
            chk("rstw ready", {31'h0, req_ready}, 32'h1);
        end
        chk("rstw mem", mem[4], 32'h5A5A5A5A);
        chk("rstw raddr", mem_raddr, 32'h0);

        // Reset mid-load drops the response.
        drive_req(0, 2'b10, 0, 32'h0, 32'h0, "rstl");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstl no resp", {31'h0, resp_valid}, 32'h0);
        end

        // Reset while in RESP drops the response.
        drive_req(0, 2'b00, 1, 32'h02, 32'h0, "rstr");
        repeat (3) @(negedge clk);
        chk("rstr valid", {31'h0, resp_valid}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstr dropped", {31'h0, resp_valid}, 32'h0);
        chk("rstr data", resp_data, 32'h0);
        chk("rstr ready", {31'h0, req_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
